dragon_body: RTL

Position-history chain that turns the dragon head's single position/direction stream into the trailing body segments. It sits directly downstream of the head movement logic and consumes its `dragon_pos`/`dragon_direction` outputs. It publishes per-segment tile positions, directions and an active mask to the sprite renderer, and a self-collision flag to game control. Body growth and shrink are driven by game events.

---
 rtl/dragon_body_if.sv | 28 ++
 rtl/dragon_body.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/dragon_body_if.sv
// dragon_body_if: bundles the head stream, growth events and the published
// body state between the head movement logic, dragon_body and its consumers.
// The master side drives the head position/direction and grow/shrink pulses;
// the slave side (dragon_body) drives the segment outputs.
interface dragon_body_if #(
    parameter int MAX_LEN = 8
);
    logic [7:0]           head_pos;
    logic [1:0]           head_dir;
    logic                 grow;
    logic                 shrink;
    logic [8*MAX_LEN-1:0] seg_pos;
    logic [2*MAX_LEN-1:0] seg_dir;
    logic [MAX_LEN-1:0]   seg_active;
    logic [3:0]           body_len;
    logic                 step;
    logic                 self_hit;

    modport master (
        output head_pos, head_dir, grow, shrink,
        input  seg_pos, seg_dir, seg_active, body_len, step, self_hit
    );

    modport slave (
        input  head_pos, head_dir, grow, shrink,
        output seg_pos, seg_dir, seg_active, body_len, step, self_hit
    );
endinterface

// File: rtl/dragon_body.sv
// dragon_body: position-history chain turning the head's position/direction
// stream into trailing body segments, with grow/shrink length control and an
// optional self-collision detector.
// Optional feature macro: DRAGON_BODY_COLLISION_EN builds the comparator array
// and the self_hit register; without it self_hit is tied low.
module dragon_body #(
    parameter int MAX_LEN  = 8,
    parameter int INIT_LEN = 2
) (
    input  logic           clk,
    input  logic           reset,
    dragon_body_if.slave   bus
);

    localparam logic [3:0] MAX_LEN_L  = 4'(MAX_LEN);
    localparam logic [3:0] INIT_LEN_L = 4'(INIT_LEN);

    // Thermometer mask with the lowest len bits set.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [3:0] len);
        logic [MAX_LEN-1:0] m;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (4'(i) < len);
        end
        return m;
    endfunction

    logic [7:0]         seg_pos_q [MAX_LEN];
    logic [1:0]         seg_dir_q [MAX_LEN];
    logic [7:0]         prev_pos;
    logic [1:0]         prev_dir;
    logic               step_q;
    logic [3:0]         body_len_q;
    logic [MAX_LEN-1:0] active_q;
    logic               grow_pending;

    logic               step_now;
    logic [3:0]         len_next;
    logic               pending_next;

    assign step_now = (bus.head_pos != prev_pos);

    // Shift the history chain whenever the head moves; direction always tracks.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_pos_q[i] <= 8'h00;
                seg_dir_q[i] <= 2'b00;
            end
            prev_pos <= 8'h00;
            prev_dir <= 2'b00;
            step_q   <= 1'b0;
        end else begin
            prev_dir <= bus.head_dir;
            step_q   <= step_now;
            if (step_now) begin
                seg_pos_q[0] <= prev_pos;
                seg_dir_q[0] <= prev_dir;
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_pos_q[i] <= seg_pos_q[i-1];
                    seg_dir_q[i] <= seg_dir_q[i-1];
                end
                prev_pos <= bus.head_pos;
            end
        end
    end

    // Next length and pending-grow state: a simultaneous grow+shrink pair has
    // no effect, shrink first cancels a pending grow, and a pending grow is
    // only realised on a step so the new tail shows real history.
    always_comb begin
        len_next     = body_len_q;
        pending_next = grow_pending;
        if (bus.shrink && !bus.grow) begin
            if (grow_pending) begin
                pending_next = 1'b0;
            end else if (body_len_q > 4'd1) begin
                len_next = body_len_q - 4'd1;
            end
        end else if (step_now && grow_pending) begin
            if (body_len_q < MAX_LEN_L) begin
                len_next = body_len_q + 4'd1;
            end
            pending_next = 1'b0;
        end else if (bus.grow && !bus.shrink) begin
            pending_next = 1'b1;
        end
    end

    // Register length, its active mask and the pending-grow flag together.
    always_ff @(posedge clk) begin
        if (reset) begin
            body_len_q   <= INIT_LEN_L;
            active_q     <= len_mask(INIT_LEN_L);
            grow_pending <= 1'b0;
        end else begin
            body_len_q   <= len_next;
            active_q     <= len_mask(len_next);
            grow_pending <= pending_next;
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign bus.seg_pos[8*g +: 8] = seg_pos_q[g];
        assign bus.seg_dir[2*g +: 2] = seg_dir_q[g];
    end

    assign bus.seg_active = active_q;
    assign bus.body_len   = body_len_q;
    assign bus.step       = step_q;

`ifdef DRAGON_BODY_COLLISION_EN
    logic hit_any;
    logic self_hit_q;

    // Compare the head against every active segment tile.
    always_comb begin
        hit_any = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (active_q[i] && (seg_pos_q[i] == bus.head_pos)) begin
                hit_any = 1'b1;
            end
        end
    end

    // Register the hit only once the chain has absorbed the head's last move,
    // so a stale pre-shift segment set never produces a hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            self_hit_q <= 1'b0;
        end else begin
            self_hit_q <= hit_any && !step_now;
        end
    end

    assign bus.self_hit = self_hit_q;
`else
    assign bus.self_hit = 1'b0;
`endif

endmodule
